memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 217 +++++++++++++++++++++
 tb/tb_memory_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store memory stage with single-outstanding data bus access
module memory_stage (
    input  logic        clk,
    input  logic        nrst,
    input  logic        ex_valid,
    input  logic        ex_flush,
    input  logic        ex_dread,
    input  logic [1:0]  ex_dwrite,
    input  logic [1:0]  ex_reg_wr_mem,
    input  logic        ex_reg_wr_mem_signed,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rdat2,
    input  logic [4:0]  ex_rd,
    output logic        dbus_req,
    output logic        dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_strb,
    input  logic        dbus_ready,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_misaligned
);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic        dbus_req_q, dbus_req_d;
    logic        dbus_wen_q, dbus_wen_d;
    logic [31:0] dbus_addr_q, dbus_addr_d;
    logic [31:0] dbus_wdata_q, dbus_wdata_d;
    logic [3:0]  dbus_strb_q, dbus_strb_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_wen_q, wb_wen_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mem_misaligned_q, mem_misaligned_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_signed_q, ld_signed_d;
    logic        is_load_q, is_load_d;
    logic        killed_q, killed_d;

    logic        is_access;
    logic        half_acc;
    logic        word_acc;
    logic        misaligned;
    logic        accept;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_data;

    always_comb begin
        is_access  = ex_dread | (ex_dwrite != 2'd0);
        half_acc   = (ex_dread && ex_reg_wr_mem == 2'd1) || (ex_dwrite == 2'd2);
        word_acc   = (ex_dread && ex_reg_wr_mem[1]) || (ex_dwrite == 2'd3);
        misaligned = (half_acc && ex_alu_out[0]) || (word_acc && (ex_alu_out[1:0] != 2'd0));
        accept     = (state_q == ST_IDLE) && ex_valid && !ex_flush && is_access && !misaligned;
        mem_stall  = accept || (state_q == ST_BUSY);
    end

    // Store lanes: narrow data is replicated so every lane carries it; strobes pick the target.
    always_comb begin
        st_strb  = 4'b0000;
        st_wdata = 32'd0;
        case (ex_dwrite)
            2'd1: begin
                st_strb  = 4'b0001 << ex_alu_out[1:0];
                st_wdata = {4{ex_rdat2[7:0]}};
            end
            2'd2: begin
                st_strb  = 4'b0011 << ex_alu_out[1:0];
                st_wdata = {2{ex_rdat2[15:0]}};
            end
            2'd3: begin
                st_strb  = 4'b1111;
                st_wdata = ex_rdat2;
            end
            default: begin
                st_strb  = 4'b0000;
                st_wdata = 32'd0;
            end
        endcase
    end

    always_comb begin
        ld_shift = dbus_rdata >> {ld_off_q, 3'b000};
        case (ld_size_q)
            2'd0:    ld_data = {{24{ld_signed_q & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_data = {{16{ld_signed_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        dbus_req_d       = dbus_req_q;
        dbus_wen_d       = dbus_wen_q;
        dbus_addr_d      = dbus_addr_q;
        dbus_wdata_d     = dbus_wdata_q;
        dbus_strb_d      = dbus_strb_q;
        wb_valid_d       = 1'b0;
        wb_wen_d         = wb_wen_q;
        wb_rd_d          = wb_rd_q;
        wb_data_d        = wb_data_q;
        mem_misaligned_d = 1'b0;
        ld_off_d         = ld_off_q;
        ld_size_d        = ld_size_q;
        ld_signed_d      = ld_signed_q;
        is_load_d        = is_load_q;
        killed_d         = killed_q;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && !ex_flush) begin
                    wb_rd_d = ex_rd;
                    if (!is_access) begin
                        wb_valid_d = 1'b1;
                        wb_wen_d   = (ex_rd != 5'd0);
                        wb_data_d  = ex_alu_out;
                    end else if (misaligned) begin
                        wb_valid_d       = 1'b1;
                        wb_wen_d         = 1'b0;
                        wb_data_d        = ex_alu_out;
                        mem_misaligned_d = 1'b1;
                    end else begin
                        dbus_req_d   = 1'b1;
                        dbus_wen_d   = (ex_dwrite != 2'd0);
                        dbus_addr_d  = {ex_alu_out[31:2], 2'b00};
                        dbus_wdata_d = st_wdata;
                        dbus_strb_d  = st_strb;
                        ld_off_d     = ex_alu_out[1:0];
                        ld_size_d    = ex_reg_wr_mem;
                        ld_signed_d  = ex_reg_wr_mem_signed;
                        is_load_d    = ex_dread && (ex_dwrite == 2'd0);
                        killed_d     = 1'b0;
                        state_d      = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // A flush cannot cancel a bus cycle already in progress; it only suppresses writeback.
                if (ex_flush) begin
                    killed_d = 1'b1;
                end
                if (dbus_ready) begin
                    dbus_req_d = 1'b0;
                    dbus_wen_d = 1'b0;
                    wb_data_d  = ld_data;
                    wb_wen_d   = is_load_q && !killed_q && !ex_flush;
                    wb_valid_d = !killed_q && !ex_flush;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q          <= ST_IDLE;
            dbus_req_q       <= 1'b0;
            dbus_wen_q       <= 1'b0;
            dbus_addr_q      <= 32'd0;
            dbus_wdata_q     <= 32'd0;
            dbus_strb_q      <= 4'd0;
            wb_valid_q       <= 1'b0;
            wb_wen_q         <= 1'b0;
            wb_rd_q          <= 5'd0;
            wb_data_q        <= 32'd0;
            mem_misaligned_q <= 1'b0;
            ld_off_q         <= 2'd0;
            ld_size_q        <= 2'd0;
            ld_signed_q      <= 1'b0;
            is_load_q        <= 1'b0;
            killed_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            dbus_req_q       <= dbus_req_d;
            dbus_wen_q       <= dbus_wen_d;
            dbus_addr_q      <= dbus_addr_d;
            dbus_wdata_q     <= dbus_wdata_d;
            dbus_strb_q      <= dbus_strb_d;
            wb_valid_q       <= wb_valid_d;
            wb_wen_q         <= wb_wen_d;
            wb_rd_q          <= wb_rd_d;
            wb_data_q        <= wb_data_d;
            mem_misaligned_q <= mem_misaligned_d;
            ld_off_q         <= ld_off_d;
            ld_size_q        <= ld_size_d;
            ld_signed_q      <= ld_signed_d;
            is_load_q        <= is_load_d;
            killed_q         <= killed_d;
        end
    end

    assign dbus_req       = dbus_req_q;
    assign dbus_wen       = dbus_wen_q;
    assign dbus_addr      = dbus_addr_q;
    assign dbus_wdata     = dbus_wdata_q;
    assign dbus_strb      = dbus_strb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_wen         = wb_wen_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign mem_misaligned = mem_misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench for memory_stage
module tb_memory_stage;

    logic        clk;
    logic        nrst;
    logic        ex_valid;
    logic        ex_flush;
    logic        ex_dread;
    logic [1:0]  ex_dwrite;
    logic [1:0]  ex_reg_wr_mem;
    logic        ex_reg_wr_mem_signed;
    logic [31:0] ex_alu_out;
    logic [31:0] ex_rdat2;
    logic [4:0]  ex_rd;
    logic        dbus_req;
    logic        dbus_wen;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_strb;
    logic        dbus_ready;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    memory_stage dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .ex_valid             (ex_valid),
        .ex_flush             (ex_flush),
        .ex_dread             (ex_dread),
        .ex_dwrite            (ex_dwrite),
        .ex_reg_wr_mem        (ex_reg_wr_mem),
        .ex_reg_wr_mem_signed (ex_reg_wr_mem_signed),
        .ex_alu_out           (ex_alu_out),
        .ex_rdat2             (ex_rdat2),
        .ex_rd                (ex_rd),
        .dbus_req             (dbus_req),
        .dbus_wen             (dbus_wen),
        .dbus_addr            (dbus_addr),
        .dbus_wdata           (dbus_wdata),
        .dbus_strb            (dbus_strb),
        .dbus_ready           (dbus_ready),
        .dbus_rdata           (dbus_rdata),
        .mem_stall            (mem_stall),
        .wb_valid             (wb_valid),
        .wb_wen               (wb_wen),
        .wb_rd                (wb_rd),
        .wb_data              (wb_data),
        .mem_misaligned       (mem_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid             = 1'b0;
        ex_flush             = 1'b0;
        ex_dread             = 1'b0;
        ex_dwrite            = 2'd0;
        ex_reg_wr_mem        = 2'd0;
        ex_reg_wr_mem_signed = 1'b0;
        ex_alu_out           = 32'd0;
        ex_rdat2             = 32'd0;
        ex_rd                = 5'd0;
        dbus_ready           = 1'b0;
        dbus_rdata           = 32'd0;
    endtask

    // Drives one instruction from an idle stage and checks it to completion against
    // expectations computed directly from the access rules.
    task automatic run_op(input logic v, input logic fl, input logic rd_en,
                          input logic [1:0] wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input logic [31:0] rdat, input int waits, input logic fl_busy);
        int          off;
        int          nbytes;
        int          stall_cnt;
        logic        access;
        logic        mis;
        logic        go;
        logic [31:0] part;
        logic [31:0] exp_ld;
        logic [31:0] exp_wd;
        logic [31:0] exp_strb;

        off    = int'(a % 4);
        access = rd_en || (wr != 2'd0);
        if (rd_en) nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        else       nbytes = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
        mis = access && ((a % nbytes) != 0);
        go  = v && !fl;

        if (sz == 2'd0) begin
            part   = (rdat >> (8 * off)) & 32'hFF;
            exp_ld = (sg && part >= 32'h80) ? (part | 32'hFFFFFF00) : part;
        end else if (sz == 2'd1) begin
            part   = (rdat >> (8 * off)) & 32'hFFFF;
            exp_ld = (sg && part >= 32'h8000) ? (part | 32'hFFFF0000) : part;
        end else begin
            exp_ld = rdat;
        end
        if (wr == 2'd1) begin
            exp_strb = 32'(1 << off);
            exp_wd   = (d & 32'hFF) * 32'h01010101;
        end else if (wr == 2'd2) begin
            exp_strb = 32'(3 << off);
            exp_wd   = (d & 32'hFFFF) * 32'h00010001;
        end else begin
            exp_strb = (wr == 2'd3) ? 32'hF : 32'h0;
            exp_wd   = d;
        end

        ex_valid             = v;
        ex_flush             = fl;
        ex_dread             = rd_en;
        ex_dwrite            = wr;
        ex_reg_wr_mem        = sz;
        ex_reg_wr_mem_signed = sg;
        ex_alu_out           = a;
        ex_rdat2             = d;
        ex_rd                = rd;
        #1;
        chk("stall_accept", 32'(mem_stall), 32'(go && access && !mis));
        stall_cnt = mem_stall ? 1 : 0;
        tick();

        if (go && access && !mis) begin
            chk("req_set", 32'(dbus_req), 32'd1);
            chk("wen", 32'(dbus_wen), 32'(wr != 2'd0));
            chk("addr", dbus_addr, a & 32'hFFFFFFFC);
            if (wr != 2'd0) begin
                chk("strb", 32'(dbus_strb), exp_strb);
                chk("wdata", dbus_wdata, exp_wd);
            end
            chk("wb_valid_busy", 32'(wb_valid), 32'd0);
            for (int i = 0; i <= waits; i++) begin
                dbus_ready = (i == waits);
                dbus_rdata = (i == waits) ? rdat : $urandom;
                if (fl_busy) ex_flush = 1'b1;
                #1;
                if (mem_stall) stall_cnt++;
                tick();
                if (i < waits) chk("req_hold", 32'(dbus_req), 32'd1);
            end
            dbus_ready = 1'b0;
            chk("stall_cnt", 32'(stall_cnt), 32'(waits + 2));
            chk("req_drop", 32'(dbus_req), 32'd0);
            chk("wb_valid_done", 32'(wb_valid), 32'(!fl_busy));
            if (!fl_busy) begin
                chk("wb_wen_mem", 32'(wb_wen), 32'(rd_en));
                if (rd_en) begin
                    chk("wb_data_ld", wb_data, exp_ld);
                    chk("wb_rd_ld", 32'(wb_rd), 32'(rd));
                end
            end
            #1;
            chk("stall_done", 32'(mem_stall), 32'd0);
        end else if (go && access) begin
            chk("mis_pulse", 32'(mem_misaligned), 32'd1);
            chk("mis_wb_valid", 32'(wb_valid), 32'd1);
            chk("mis_wb_wen", 32'(wb_wen), 32'd0);
            chk("mis_no_req", 32'(dbus_req), 32'd0);
        end else if (go) begin
            chk("alu_wb_valid", 32'(wb_valid), 32'd1);
            chk("alu_wb_data", wb_data, a);
            chk("alu_wb_wen", 32'(wb_wen), 32'(rd != 5'd0));
            chk("alu_wb_rd", 32'(wb_rd), 32'(rd));
        end else begin
            chk("drop_wb_valid", 32'(wb_valid), 32'd0);
            chk("drop_no_req", 32'(dbus_req), 32'd0);
        end

        idle_inputs();
        tick();
        chk("tail_wb_valid", 32'(wb_valid), 32'd0);
        chk("tail_mis", 32'(mem_misaligned), 32'd0);
        chk("tail_req", 32'(dbus_req), 32'd0);
    endtask

    initial begin
        logic        r_v, r_fl, r_rd_en, r_sg, r_fb;
        logic [1:0]  r_wr, r_sz;
        logic [31:0] r_a, r_d, r_rdat;
        logic [4:0]  r_rd;
        int          kind;
        int          r_waits;

        idle_inputs();
        nrst = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_wen", 32'(dbus_wen), 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_wdata", dbus_wdata, 32'd0);
        chk("rst_strb", 32'(dbus_strb), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_mis", 32'(mem_misaligned), 32'd0);
        nrst = 1'b1;

        // LW 0x100, one wait state: three stall cycles
        run_op(1, 0, 1, 2'd0, 2'd2, 0, 32'h100, 32'h0, 5'd3, 32'hDEADBEEF, 1, 0);
        run_op(1, 0, 1, 2'd0, 2'd0, 1, 32'h103, 32'h0, 5'd4, 32'h80FF0000, 0, 0);
        run_op(1, 0, 1, 2'd0, 2'd0, 0, 32'h103, 32'h0, 5'd4, 32'h80FF0000, 0, 0);
        run_op(1, 0, 0, 2'd2, 2'd0, 0, 32'h102, 32'h1234ABCD, 5'd5, 32'h0, 0, 0);
        run_op(1, 0, 1, 2'd0, 2'd2, 0, 32'h101, 32'h0, 5'd6, 32'h0, 0, 0);
        run_op(1, 0, 1, 2'd0, 2'd1, 1, 32'h202, 32'h0, 5'd7, 32'h9ABC0000, 2, 1);
        run_op(1, 1, 1, 2'd0, 2'd2, 0, 32'h300, 32'h0, 5'd8, 32'h0, 0, 0);
        run_op(1, 0, 0, 2'd0, 2'd0, 0, 32'hCAFE0001, 32'h0, 5'd0, 32'h0, 0, 0);

        // reset while a bus cycle is outstanding
        ex_valid      = 1'b1;
        ex_dread      = 1'b1;
        ex_reg_wr_mem = 2'd2;
        ex_alu_out    = 32'h400;
        ex_rd         = 5'd9;
        tick();
        chk("rstbusy_req_before", 32'(dbus_req), 32'd1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        idle_inputs();
        #1;
        chk("rstbusy_req", 32'(dbus_req), 32'd0);
        chk("rstbusy_addr", dbus_addr, 32'd0);
        chk("rstbusy_idle", 32'(mem_stall), 32'd0);
        tick();
        chk("rstbusy_wb_valid", 32'(wb_valid), 32'd0);

        for (int n = 0; n < 120; n++) begin
            kind    = $urandom_range(0, 3);
            r_v     = ($urandom_range(0, 7) != 0);
            r_fl    = ($urandom_range(0, 7) == 0);
            r_rd_en = (kind < 2);
            r_wr    = (kind == 2) ? 2'($urandom_range(1, 3)) : 2'd0;
            r_sz    = 2'($urandom_range(0, 2));
            r_sg    = 1'($urandom);
            r_a     = $urandom;
            r_d     = $urandom;
            r_rd    = 5'($urandom);
            r_rdat  = $urandom;
            r_waits = $urandom_range(0, 3);
            r_fb    = ($urandom_range(0, 5) == 0);
            run_op(r_v, r_fl, r_rd_en, r_wr, r_sz, r_sg, r_a, r_d, r_rd, r_rdat, r_waits, r_fb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
